// File: rtl/drca_sequencer.sv
// Sequencer for one dynamic ripple-carry adder: accepts operands, waits only as long as the
// operands' longest propagate chain needs, then returns {Cout,S}. Optional stats: DRCA_SEQ_STATS_EN.
module drca_sequencer #(
  parameter int N     = 16,
  parameter int BPC   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:0]       out_sum,
  output logic [CNT_W-1:0] out_cycles,
  output logic             busy,
  output logic             add_en,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_cin,
  input  logic [N-1:0]     add_s,
  input  logic             add_cout
`ifdef DRCA_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_cycles
`endif
);

  localparam int LW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_q, w_d;
  logic [N-1:0]     add_a_q, add_a_d;
  logic [N-1:0]     add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic [N:0]       sum_q, sum_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic [N-1:0]     prop;
  logic [LW-1:0]    run_len;
  logic [LW-1:0]    l_max;
  logic [CNT_W-1:0] wait_w;
  logic             out_hs;

  // Longest run of propagate bits bounds how far a carry can ripple.
  assign prop = in_a ^ in_b;

  always_comb begin
    run_len = '0;
    l_max   = '0;
    for (int i = 0; i < N; i++) begin
      if (prop[i]) begin
        run_len = run_len + LW'(1);
      end else begin
        run_len = '0;
      end
      if (run_len > l_max) begin
        l_max = run_len;
      end
    end
  end

  assign wait_w = CNT_W'(l_max / LW'(BPC)) + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
    sum_d     = sum_q;
    cyc_d     = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          add_a_d   = in_a;
          add_b_d   = in_b;
          add_cin_d = in_cin;
          cnt_d     = wait_w;
          w_d       = wait_w;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          sum_d   = {add_cout, add_s};
          cyc_d   = w_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      w_q       <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      sum_q     <= '0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
      sum_q     <= sum_d;
      cyc_q     <= cyc_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign add_en     = (state_q == S_WAIT);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_cin    = add_cin_q;
  assign out_sum    = sum_q;
  assign out_cycles = cyc_q;
  assign out_hs     = out_valid & out_ready;

`ifdef DRCA_SEQ_STATS_EN
  logic [CNT_W-1:0] stat_ops_q, stat_ops_d;
  logic [CNT_W-1:0] stat_cyc_q, stat_cyc_d;
  logic [CNT_W:0]   cyc_acc;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stat_ops_d = stat_ops_q;
    stat_cyc_d = stat_cyc_q;
    cyc_acc    = {1'b0, stat_cyc_q} + {1'b0, cyc_q};
    if (out_hs) begin
      stat_ops_d = (&stat_ops_q) ? stat_ops_q : stat_ops_q + CNT_W'(1);
      stat_cyc_d = cyc_acc[CNT_W] ? {CNT_W{1'b1}} : cyc_acc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q <= '0;
      stat_cyc_q <= '0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_cyc_q <= stat_cyc_d;
    end
  end

  assign stat_ops    = stat_ops_q;
  assign stat_cycles = stat_cyc_q;
`else
  logic unused_hs;
  assign unused_hs = out_hs;
`endif

endmodule
